// File: rtl/reg_writeback.sv
// Register-file write side: ALU hold reg, load FIFO, round-robin write port.
// Optional WB_BYPASS_EN forwards the pending write onto the operand outputs.
module reg_writeback #(
  parameter int TAM       = 16,
  parameter int MEM_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alu_valid,
  input  logic [3:0]     alu_sel,
  input  logic [TAM-1:0] alu_data,
  output logic           alu_ready,
  input  logic           mem_valid,
  input  logic [3:0]     mem_sel,
  input  logic [TAM-1:0] mem_data,
  output logic           mem_ready,
  input  logic           iss_valid,
  input  logic [3:0]     iss_sel,
  output logic [15:0]    busy,
  output logic           wr_en,
  output logic [3:0]     wr_sel,
  output logic [TAM-1:0] wr_data,
  input  logic [3:0]     rd_selA,
  input  logic [3:0]     rd_selB,
  input  logic [TAM-1:0] rf_outA,
  input  logic [TAM-1:0] rf_outB,
  output logic [TAM-1:0] opA,
  output logic [TAM-1:0] opB
);

  localparam int PW = $clog2(MEM_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic           hold_v;
  logic [3:0]     hold_sel;
  logic [TAM-1:0] hold_data;

  logic [3:0]     fifo_sel  [MEM_DEPTH];
  logic [TAM-1:0] fifo_data [MEM_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  src_e           last_grant;
  logic           mem_has;
  logic           alu_gnt;
  logic           mem_gnt;
  logic           any_gnt;
  logic [3:0]     gnt_sel;
  logic [TAM-1:0] gnt_data;
  logic           alu_push;
  logic           mem_push;
  logic [15:0]    busy_nxt;

  // Round-robin choice between the two buffers; ties go to the
  // source that did not win last.
  always_comb begin
    mem_has  = (count != '0);
    alu_gnt  = hold_v & (~mem_has | (last_grant == SRC_MEM));
    mem_gnt  = mem_has & ~alu_gnt;
    any_gnt  = alu_gnt | mem_gnt;
    gnt_sel  = hold_sel;
    gnt_data = hold_data;
    if (mem_gnt) begin
      gnt_sel  = fifo_sel[rd_ptr];
      gnt_data = fifo_data[rd_ptr];
    end
  end

  assign alu_ready = ~hold_v | alu_gnt;
  assign mem_ready = (count < CW'(MEM_DEPTH)) | mem_gnt;
  assign alu_push  = alu_valid & alu_ready;
  assign mem_push  = mem_valid & mem_ready;

  // ALU hold register: refill allowed in the cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_sel  <= '0;
      hold_data <= '0;
    end else if (alu_push) begin
      hold_v    <= 1'b1;
      hold_sel  <= alu_sel;
      hold_data <= alu_data;
    end else if (alu_gnt) begin
      hold_v    <= 1'b0;
    end
  end

  // Load FIFO storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      fifo_sel[wr_ptr]  <= mem_sel;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // Load FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (mem_push) wr_ptr <= wr_ptr + PW'(1);
      if (mem_gnt)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({mem_push, mem_gnt})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the winner so the other source goes first next tie.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= SRC_MEM;
    else if (any_gnt)
      last_grant <= mem_gnt ? SRC_MEM : SRC_ALU;
  end

  // Registered write port; select and data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any_gnt;
      if (any_gnt) begin
        wr_sel  <= gnt_sel;
        wr_data <= gnt_data;
      end
    end
  end

  // Scoreboard next state: a new issue beats the retiring write.
  always_comb begin
    busy_nxt = busy;
    if (any_gnt)   busy_nxt[gnt_sel] = 1'b0;
    if (iss_valid) busy_nxt[iss_sel] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

`ifdef WB_BYPASS_EN
  assign opA = (wr_en && wr_sel == rd_selA) ? wr_data : rf_outA;
  assign opB = (wr_en && wr_sel == rd_selB) ? wr_data : rf_outB;
`else
  logic unused_rd_sel;
  assign unused_rd_sel = ^{rd_selA, rd_selB};
  assign opA = rf_outA;
  assign opB = rf_outB;
`endif

endmodule
